// File: rtl/full_sub_b_case_if.sv
// Operand/result bundle for full_sub_b_case.
// FULL_SUB_STICKY_BORROW_EN adds the sticky underflow pair.
interface full_sub_b_case_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic [WIDTH-1:0] d;
  logic             borrow_out;
  logic             out_valid;
`ifdef FULL_SUB_STICKY_BORROW_EN
  logic             sticky_clr;
  logic             underflow_sticky;

  modport master (output in_valid, a, b, borrow_in, sticky_clr,
                  input  d, borrow_out, out_valid, underflow_sticky);
  modport slave  (input  in_valid, a, b, borrow_in, sticky_clr,
                  output d, borrow_out, out_valid, underflow_sticky);
`else
  modport master (output in_valid, a, b, borrow_in,
                  input  d, borrow_out, out_valid);
  modport slave  (input  in_valid, a, b, borrow_in,
                  output d, borrow_out, out_valid);
`endif
endinterface

// File: rtl/full_sub_b_case.sv
// Registered ripple-borrow subtractor: {borrow_out,d} = a - b - borrow_in, 1-cycle latency.
// Optional FULL_SUB_STICKY_BORROW_EN adds a sticky underflow flag with clear.
module full_sub_b_case_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  always_comb begin
    o_d    = 1'b0;
    o_bout = 1'b0;
    case ({i_a, i_b, i_bin})
      3'b000: begin o_d = 1'b0; o_bout = 1'b0; end
      3'b001: begin o_d = 1'b1; o_bout = 1'b1; end
      3'b010: begin o_d = 1'b1; o_bout = 1'b1; end
      3'b011: begin o_d = 1'b0; o_bout = 1'b1; end
      3'b100: begin o_d = 1'b1; o_bout = 1'b0; end
      3'b101: begin o_d = 1'b0; o_bout = 1'b0; end
      3'b110: begin o_d = 1'b0; o_bout = 1'b0; end
      3'b111: begin o_d = 1'b1; o_bout = 1'b1; end
      default: begin o_d = 1'b0; o_bout = 1'b0; end
    endcase
  end
endmodule

module full_sub_b_case #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  full_sub_b_case_if.slave bus
);
  logic [WIDTH:0]   w_bin;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_vld;

  assign w_bin[0] = bus.borrow_in;

  // Borrow ripples LSB->MSB; w_bin[WIDTH] is the full-width borrow out.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      full_sub_b_case_slice u_slice (
        .i_a    (bus.a[gi]),
        .i_b    (bus.b[gi]),
        .i_bin  (w_bin[gi]),
        .o_d    (w_d[gi]),
        .o_bout (w_bin[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d    <= '0;
      r_bout <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_d    <= w_d;
        r_bout <= w_bin[WIDTH];
      end
    end
  end

  assign bus.d          = r_d;
  assign bus.borrow_out = r_bout;
  assign bus.out_valid  = r_vld;

`ifdef FULL_SUB_STICKY_BORROW_EN
  logic r_sticky;

  // A new underflow beats a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_sticky <= 1'b0;
    else if (bus.in_valid && w_bin[WIDTH])
      r_sticky <= 1'b1;
    else if (bus.sticky_clr)
      r_sticky <= 1'b0;
  end

  assign bus.underflow_sticky = r_sticky;
`endif
endmodule

// File: tb/tb_full_sub_b_case.sv
// Directed + model-checked bench for full_sub_b_case at WIDTH=1 and WIDTH=8.
module tb_full_sub_b_case;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  full_sub_b_case_if #(.WIDTH(1)) u_if1 ();
  full_sub_b_case_if #(.WIDTH(8)) u_if8 ();

  full_sub_b_case #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));
  full_sub_b_case #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(u_if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic a, input logic b, input logic bin);
    u_if1.in_valid  = v;
    u_if1.a         = a;
    u_if1.b         = b;
    u_if1.borrow_in = bin;
  endtask

  task automatic drv8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
    u_if8.in_valid  = v;
    u_if8.a         = a;
    u_if8.b         = b;
    u_if8.borrow_in = bin;
  endtask

  initial begin
    logic [7:0] t_d;
    logic [7:0] t_bo;
    logic [8:0] m_res;
    logic [7:0] m_d;
    logic       m_bo;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    logic       rv;
    logic [2:0] sel;

    n_chk  = 0;
    n_fail = 0;
    // d / bout per selector {a,b,bin}, index 0..7
    t_d  = 8'b1001_0110;
    t_bo = 8'b1000_1110;

    rst_n = 1'b0;
    drv1(1'b1, 1'b1, 1'b0, 1'b0);
    drv8(1'b1, 8'h01, 8'h00, 1'b0);
`ifdef FULL_SUB_STICKY_BORROW_EN
    u_if1.sticky_clr = 1'b0;
    u_if8.sticky_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_d1",  32'(u_if1.d),          32'h0);
    chk("rst_bo1", 32'(u_if1.borrow_out), 32'h0);
    chk("rst_ov1", 32'(u_if1.out_valid),  32'h0);
    chk("rst_d8",  32'(u_if8.d),          32'h0);
    chk("rst_ov8", 32'(u_if8.out_valid),  32'h0);
`ifdef FULL_SUB_STICKY_BORROW_EN
    chk("rst_sticky", 32'(u_if1.underflow_sticky), 32'h0);
`endif

    rst_n = 1'b1;
    tick();
    chk("post_rst_d1",  32'(u_if1.d),         32'h1);
    chk("post_rst_ov1", 32'(u_if1.out_valid), 32'h1);
    chk("post_rst_d8",  32'(u_if8.d),         32'h01);

    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      drv1(1'b1, sel[2], sel[1], sel[0]);
      tick();
      chk($sformatf("exh_d_%0d", i),  32'(u_if1.d),          32'(t_d[i]));
      chk($sformatf("exh_bo_%0d", i), 32'(u_if1.borrow_out), 32'(t_bo[i]));
      chk($sformatf("exh_ov_%0d", i), 32'(u_if1.out_valid),  32'h1);
    end

    // last vector was 111 -> d=1, bout=1; invalid input must not disturb it
    drv1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("hold_d",  32'(u_if1.d),          32'h1);
    chk("hold_bo", 32'(u_if1.borrow_out), 32'h1);
    chk("hold_ov", 32'(u_if1.out_valid),  32'h0);

    drv8(1'b1, 8'h00, 8'hFF, 1'b1);
    tick();
    chk("wrap_d",  32'(u_if8.d),          32'h00);
    chk("wrap_bo", 32'(u_if8.borrow_out), 32'h1);
    drv8(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    chk("r80_d",  32'(u_if8.d),          32'h7F);
    chk("r80_bo", 32'(u_if8.borrow_out), 32'h0);
    drv8(1'b1, 8'h5A, 8'h5A, 1'b0);
    tick();
    chk("eq_d",  32'(u_if8.d),          32'h00);
    chk("eq_bo", 32'(u_if8.borrow_out), 32'h0);
    drv8(1'b1, 8'h5A, 8'h5A, 1'b1);
    tick();
    chk("eqb_d",  32'(u_if8.d),          32'hFF);
    chk("eqb_bo", 32'(u_if8.borrow_out), 32'h1);

    m_d  = 8'hFF;
    m_bo = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      rv   = ($urandom_range(0, 7) != 0);
      drv8(rv, ra, rb, rbin);
      if (rv) begin
        m_res = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
        m_d   = m_res[7:0];
        m_bo  = m_res[8];
      end
      tick();
      chk("rnd_d",  32'(u_if8.d),          32'(m_d));
      chk("rnd_bo", 32'(u_if8.borrow_out), 32'(m_bo));
      chk("rnd_ov", 32'(u_if8.out_valid),  32'(rv));
    end

`ifdef FULL_SUB_STICKY_BORROW_EN
    drv1(1'b1, 1'b1, 1'b0, 1'b0);
    u_if1.sticky_clr = 1'b1;
    tick();
    u_if1.sticky_clr = 1'b0;
    chk("stk_clr0", 32'(u_if1.underflow_sticky), 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("stk_set", 32'(u_if1.underflow_sticky), 32'h1);
    drv1(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stk_keep", 32'(u_if1.underflow_sticky), 32'h1);
    u_if1.sticky_clr = 1'b1;
    tick();
    u_if1.sticky_clr = 1'b0;
    chk("stk_clr", 32'(u_if1.underflow_sticky), 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 1'b0);
    u_if1.sticky_clr = 1'b1;
    tick();
    u_if1.sticky_clr = 1'b0;
    chk("stk_setwins", 32'(u_if1.underflow_sticky), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
